// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: funct3 op codes,
// FSM state values and the iteration-counter width helper.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MUL  = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Wide enough to hold the iteration count XLEN itself.
  function automatic int unsigned cnt_width(input int unsigned xlen);
    return $clog2(xlen) + 1;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor if it fits, and report the resulting quotient bit.
module muldiv_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_div,
  input  logic            i_bit,
  output logic [XLEN-1:0] o_rem,
  output logic            o_q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // The partial remainder is always below the divisor, so the difference fits in XLEN bits.
  always_comb begin
    shifted = {i_rem, i_bit};
    diff    = shifted - {1'b0, i_div};
    o_q_bit = ~diff[XLEN];
    o_rem   = o_q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes and flush.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 2
) (
  input  logic            i_clk_n,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_in_a,
  input  logic [XLEN-1:0] i_in_b,
  input  logic            i_flush,
  output logic            o_res_valid,
  input  logic            i_res_ready,
  output logic [XLEN-1:0] o_alu_out,
  output logic            o_busy
);

  localparam int unsigned     CntW     = cnt_width(XLEN);
  localparam logic [CntW-1:0] DivIters = CntW'(XLEN);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [XLEN-1:0] MinVal   = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // acc holds {hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   res_q, res_d;

  // Request decode
  logic            a_signed, b_signed, sa, sb;
  logic            b_zero, ovf;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    a_signed = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
    b_signed = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
    sa       = a_signed & i_in_a[XLEN-1];
    sb       = b_signed & i_in_b[XLEN-1];
    mag_a    = sa ? ('0 - i_in_a) : i_in_a;
    mag_b    = sb ? ('0 - i_in_b) : i_in_b;
    b_zero   = (i_in_b == '0);
    ovf      = ((i_op == OP_DIV) || (i_op == OP_REM)) && (i_in_a == MinVal) && (i_in_b == '1);
  end

  // Multiply datapath
  logic [2*XLEN-1:0] mul_next;

`ifdef MULDIV_FAST_MUL_EN
  always_comb begin
    mul_next = {{XLEN{1'b0}}, opb_q} * {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
  end
`else
  localparam logic [CntW-1:0] MulIters = CntW'(XLEN / MUL_STEP);

  logic [XLEN+MUL_STEP-1:0] pp;
  logic [XLEN+MUL_STEP-1:0] mul_sum;

  // Add multiplicand * (low MUL_STEP multiplier bits) into the high half, then shift right.
  always_comb begin
    pp = '0;
    for (int unsigned k = 0; k < MUL_STEP; k++) begin
      if (acc_q[k]) begin
        pp = pp + ({{MUL_STEP{1'b0}}, opb_q} << k);
      end
    end
    mul_sum  = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]} + pp;
    mul_next = {mul_sum, acc_q[XLEN-1:MUL_STEP]};
  end
`endif

  // Divide datapath
  logic [XLEN-1:0] step_rem;
  logic            step_q;

  muldiv_div_step #(
    .XLEN(XLEN)
  ) u_div_step (
    .i_rem   (acc_q[2*XLEN-1:XLEN]),
    .i_div   (opb_q),
    .i_bit   (acc_q[XLEN-1]),
    .o_rem   (step_rem),
    .o_q_bit (step_q)
  );

  // Sign fix-up and result select
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res;

  always_comb begin
    prod_s = neg_q ? ('0 - acc_q) : acc_q;
    quo_s  = neg_q ? ('0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_s  = rneg_q ? ('0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      fix_res = op_q[1] ? rem_s : quo_s;
    end else if (op_q == OP_MUL) begin
      fix_res = prod_s[XLEN-1:0];
    end else begin
      fix_res = prod_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;

    if (i_flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            op_d   = i_op;
            neg_d  = sa ^ sb;
            rneg_d = sa;
            if (i_op[2]) begin
              acc_d   = {{XLEN{1'b0}}, mag_a};
              opb_d   = mag_b;
              cnt_d   = DivIters;
              state_d = ST_DIV;
              // Special cases preload acc so FIX yields the architectural result unsigned.
              if (b_zero || ovf) begin
                neg_d   = 1'b0;
                rneg_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_FIX;
                if (b_zero) begin
                  acc_d = {i_in_a, {XLEN{1'b1}}};
                end else begin
                  acc_d = {{XLEN{1'b0}}, MinVal};
                end
              end
            end else begin
              acc_d   = {{XLEN{1'b0}}, mag_b};
              opb_d   = mag_a;
              state_d = ST_MUL;
`ifdef MULDIV_FAST_MUL_EN
              cnt_d   = '0;
`else
              cnt_d   = MulIters;
`endif
            end
          end
        end
        ST_MUL: begin
          acc_d = mul_next;
`ifdef MULDIV_FAST_MUL_EN
          state_d = ST_FIX;
`else
          cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_d = ST_FIX;
          end
`endif
        end
        ST_DIV: begin
          acc_d = {step_rem, acc_q[XLEN-2:0], step_q};
          cnt_d = cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_d = ST_FIX;
          end
        end
        ST_FIX: begin
          res_d   = fix_res;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (i_res_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk_n or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
    end
  end

  assign o_ready     = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_res_valid = (state_q == ST_DONE);
  assign o_alu_out   = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32, MUL_STEP=2): vector table plus
// hand-written flush, reset and backpressure sequences.
module tb_muldiv_unit;

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
  localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
`ifdef MULDIV_FAST_MUL_EN
  localparam int ML = 2;
`else
  localparam int ML = 17;
`endif
  localparam int DL = 33;
  localparam int NV = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_flush, i_res_ready;
  logic [2:0]  i_op;
  logic [31:0] i_in_a, i_in_b;
  logic        o_ready, o_res_valid, o_busy;
  logic [31:0] o_alu_out;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .XLEN     (32),
    .MUL_STEP (2)
  ) dut (
    .i_clk_n     (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_op        (i_op),
    .i_in_a      (i_in_a),
    .i_in_b      (i_in_b),
    .i_flush     (i_flush),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_alu_out   (o_alu_out),
    .o_busy      (o_busy)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request, wait (bounded) for the result, then hand it back.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(posedge clk); #1;
    i_valid = 1'b1; i_op = op; i_in_a = a; i_in_b = b;
    @(posedge clk); #1;
    i_valid = 1'b0; i_in_a = $urandom; i_in_b = $urandom;
    lat = 0;
    while (!o_res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = o_alu_out;
    i_res_ready = 1'b1;
    @(posedge clk); #1;
    i_res_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    logic        saw_valid;

    vecs[0]  = '{MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, ML};
    vecs[1]  = '{MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, ML};
    vecs[2]  = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML};
    vecs[3]  = '{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, ML};
    vecs[4]  = '{MUL,    32'h12345678, 32'h00000010, 32'h23456780, ML};
    vecs[5]  = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, ML};
    vecs[6]  = '{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DL};
    vecs[7]  = '{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DL};
    vecs[8]  = '{DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DL};
    vecs[9]  = '{REM,    32'd7,        32'hFFFFFFFE, 32'd1,        DL};
    vecs[10] = '{DIVU,   32'd100,      32'd7,        32'd14,       DL};
    vecs[11] = '{REMU,   32'd100,      32'd7,        32'd2,        DL};
    vecs[12] = '{DIVU,   32'd7,        32'd0,        32'hFFFFFFFF, 1};
    vecs[13] = '{REMU,   32'd7,        32'd0,        32'd7,        1};
    vecs[14] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[15] = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};

    rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_res_ready = 1'b0;
    i_op = 3'd0; i_in_a = '0; i_in_b = '0;
    #2;
    check("reset_ready", {63'd0, o_ready}, 64'd1);
    check("reset_res_valid", {63'd0, o_res_valid}, 64'd0);
    check("reset_alu_out", {32'd0, o_alu_out}, 64'd0);
    check("reset_busy", {63'd0, o_busy}, 64'd0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_result", i), {32'd0, res}, {32'd0, vecs[i].exp});
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Flush at cycle 10 of a DIVU.
    @(posedge clk); #1;
    i_valid = 1'b1; i_op = DIVU; i_in_a = 32'd100; i_in_b = 32'd7;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    check("flush_ready", {63'd0, o_ready}, 64'd1);
    check("flush_busy", {63'd0, o_busy}, 64'd0);
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_res_valid) saw_valid = 1'b1;
    end
    check("flush_no_result", {63'd0, saw_valid}, 64'd0);
    run_op(MULHU, 32'h80000000, 32'd4, res, lat);
    check("post_flush_mulhu", {32'd0, res}, 64'd2);
    check("post_flush_latency", 64'(lat), 64'(ML));

    // Accept and flush in the same cycle: request is dropped.
    @(posedge clk); #1;
    i_valid = 1'b1; i_flush = 1'b1; i_op = DIV; i_in_a = 32'd9; i_in_b = 32'd3;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush_wins_busy", {63'd0, o_busy}, 64'd0);

    // Asynchronous reset mid-MUL.
    @(posedge clk); #1;
    i_valid = 1'b1; i_op = MUL; i_in_a = 32'd3; i_in_b = 32'd5;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ready", {63'd0, o_ready}, 64'd1);
    check("midrst_busy", {63'd0, o_busy}, 64'd0);
    check("midrst_res_valid", {63'd0, o_res_valid}, 64'd0);
    check("midrst_alu_out", {32'd0, o_alu_out}, 64'd0);
    #2 rst_n = 1'b1;
    run_op(MUL, 32'd3, 32'd5, res, lat);
    check("post_rst_mul", {32'd0, res}, 64'd15);

    // Backpressure: result held for 5 cycles while a new request is offered.
    @(posedge clk); #1;
    i_valid = 1'b1; i_op = MUL; i_in_a = 32'h12345678; i_in_b = 32'h10;
    @(posedge clk); #1;
    i_op = DIV; i_in_a = 32'd1; i_in_b = 32'd1;
    lat = 0;
    while (!o_res_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_latency", 64'(lat), 64'(ML));
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold%0d_alu_out", c), {32'd0, o_alu_out}, 64'h23456780);
      check($sformatf("bp_hold%0d_ready", c), {63'd0, o_ready}, 64'd0);
      check($sformatf("bp_hold%0d_res_valid", c), {63'd0, o_res_valid}, 64'd1);
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_res_ready = 1'b1;
    @(posedge clk); #1;
    i_res_ready = 1'b0;
    check("bp_after_ready", {63'd0, o_ready}, 64'd1);
    check("bp_after_res_valid", {63'd0, o_res_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
